eth_axis_rx_frame_filter: RTL and testbench

Ethernet frame filter between the 128-bit FCS checker output and si_data_channel, in the sys_clk domain.
It inspects the first beat of each frame and makes one decision per frame: forward the whole frame or drop it.
- Forward: destination MAC matches the configured station address (or broadcast, if enabled) and EtherType matches the configured FPGA-link EtherType.
- Drop: anything else.
It keeps saturating counters of passed, dropped and runt frames for statistics readout.

---
 rtl/eth_axis_rx_frame_filter_pkg.sv | 19 +
 rtl/eth_axis_rx_frame_filter_if.sv | 14 +
 rtl/eth_axis_rx_frame_filter_sat_counter.sv | 34 +++
 rtl/eth_axis_rx_frame_filter.sv | 128 ++++++++++++
 tb/tb_eth_axis_rx_frame_filter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_axis_rx_frame_filter_pkg.sv
// Shared constants and types for the receive-side Ethernet frame filter.
package eth_axis_rx_frame_filter_pkg;

  localparam logic [47:0] ETH_BCAST_MAC      = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned ETH_HDR_BYTES      = 14;
  localparam logic [15:0] ETH_TYPE_FPGA_LINK = 16'h88B5;

  typedef enum logic [1:0] {
    StHead,
    StPass,
    StDrop
  } filter_state_t;

  // EtherType travels big-endian: byte 12 is the high byte.
  function automatic logic [15:0] eth_type_of(input logic [127:0] beat);
    return {beat[103:96], beat[111:104]};
  endfunction

endpackage

// File: rtl/eth_axis_rx_frame_filter_if.sv
// AXI4-Stream bundle used on both sides of the frame filter.
interface eth_axis_rx_frame_filter_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/eth_axis_rx_frame_filter_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module eth_axis_rx_frame_filter_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/eth_axis_rx_frame_filter.sv
// Per-frame forward/drop filter on station MAC and EtherType, decided from beat 0,
// with one output register stage and saturating pass/drop/runt statistics.
module eth_axis_rx_frame_filter
  import eth_axis_rx_frame_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_axis_rx_frame_filter_if.slave  s_axis,
  eth_axis_rx_frame_filter_if.master m_axis,
  input  logic                   cfg_enable,
  input  logic [47:0]            cfg_mac,
  input  logic [15:0]            cfg_ethertype,
  input  logic                   cfg_accept_bcast,
  input  logic                   cnt_clear,
  output logic [CNT_WIDTH-1:0]   cnt_pass,
  output logic [CNT_WIDTH-1:0]   cnt_drop,
  output logic [CNT_WIDTH-1:0]   cnt_runt
);

  filter_state_t         state_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_valid_q;
  logic                  m_last_q;

  logic        in_hs;
  logic        out_hs;
  logic [47:0] dst_mac;
  logic [15:0] eth_type;
  logic        hdr_ok;
  logic        is_runt;
  logic        dst_ok;
  logic        is_match;
  logic        fwd_beat;
  logic        head_hs;

  // DROP never feeds the output register, so it can always sink beats.
  assign s_axis.tready = (state_q == StDrop) || !m_valid_q || m_axis.tready;
  assign in_hs         = s_axis.tvalid && s_axis.tready;
  assign out_hs        = m_valid_q && m_axis.tready;
  assign head_hs       = in_hs && (state_q == StHead);

  always_comb begin
    dst_mac  = s_axis.tdata[47:0];
    eth_type = eth_type_of(s_axis.tdata);
    hdr_ok   = &s_axis.tkeep[ETH_HDR_BYTES-1:0];
    is_runt  = !hdr_ok || (s_axis.tlast && !s_axis.tkeep[ETH_HDR_BYTES-1]);
    dst_ok   = (dst_mac == cfg_mac) || (cfg_accept_bcast && (dst_mac == ETH_BCAST_MAC));
    is_match = !cfg_enable || (dst_ok && (eth_type == cfg_ethertype));
    fwd_beat = in_hs && ((state_q == StPass) || ((state_q == StHead) && !is_runt && is_match));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHead;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      if (in_hs) begin
        unique case (state_q)
          StHead: begin
            // A single-beat frame is fully handled here and never leaves HEAD.
            if (!s_axis.tlast) begin
              state_q <= (!is_runt && is_match) ? StPass : StDrop;
            end
          end
          StPass, StDrop: begin
            if (s_axis.tlast) begin
              state_q <= StHead;
            end
          end
          default: state_q <= StHead;
        endcase
      end

      if (fwd_beat) begin
        m_data_q  <= s_axis.tdata;
        m_keep_q  <= s_axis.tkeep;
        m_last_q  <= s_axis.tlast;
        m_valid_q <= 1'b1;
      end else if (out_hs) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;

  eth_axis_rx_frame_filter_sat_counter #(
    .Width (CNT_WIDTH)
  ) u_cnt_pass (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_hs && m_last_q),
    .clr   (cnt_clear),
    .count (cnt_pass)
  );

  eth_axis_rx_frame_filter_sat_counter #(
    .Width (CNT_WIDTH)
  ) u_cnt_drop (
    .clk   (clk),
    .rst   (rst),
    .inc   (head_hs && !is_runt && !is_match),
    .clr   (cnt_clear),
    .count (cnt_drop)
  );

  eth_axis_rx_frame_filter_sat_counter #(
    .Width (CNT_WIDTH)
  ) u_cnt_runt (
    .clk   (clk),
    .rst   (rst),
    .inc   (head_hs && is_runt),
    .clr   (cnt_clear),
    .count (cnt_runt)
  );

endmodule

// File: tb/tb_eth_axis_rx_frame_filter.sv
// Bench for the frame filter: vector table, hand sequences and a frame-level model
// driving random traffic and back-pressure.
module tb_eth_axis_rx_frame_filter;

  localparam int KFwd  = 0;
  localparam int KDrop = 1;
  localparam int KRunt = 2;

  localparam logic [47:0] MacSta   = 48'h01_00_00_00_00_02;  // 02:00:00:00:00:01
  localparam logic [47:0] MacOther = 48'h02_00_00_00_00_02;  // 02:00:00:00:00:02
  localparam logic [47:0] MacBcast = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    logic [15:0] keep0;
    int          nbeats;
    bit          en;
    bit          bcast;
    int          kind;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        cfg_enable;
  logic [47:0] cfg_mac;
  logic [15:0] cfg_ethertype;
  logic        cfg_accept_bcast;
  logic        cnt_clear;
  logic [31:0] cnt_pass;
  logic [31:0] cnt_drop;
  logic [31:0] cnt_runt;

  eth_axis_rx_frame_filter_if #(.DATA_WIDTH(128)) s_if ();
  eth_axis_rx_frame_filter_if #(.DATA_WIDTH(128)) m_if ();

  eth_axis_rx_frame_filter #(
    .DATA_WIDTH (128),
    .KEEP_WIDTH (16),
    .CNT_WIDTH  (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .cfg_enable       (cfg_enable),
    .cfg_mac          (cfg_mac),
    .cfg_ethertype    (cfg_ethertype),
    .cfg_accept_bcast (cfg_accept_bcast),
    .cnt_clear        (cnt_clear),
    .cnt_pass         (cnt_pass),
    .cnt_drop         (cnt_drop),
    .cnt_runt         (cnt_runt)
  );

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    out_beats = 0;
  int    stalls = 0;
  int    ready_mode = 0;  // 0 always ready, 1 random, 2 never
  beat_t exp_q[$];
  int    lat_q[$];
  logic [31:0] exp_pass = 0;
  logic [31:0] exp_drop = 0;
  logic [31:0] exp_runt = 0;
  bit    prev_stall = 0;
  beat_t prev_beat;
  vec_t  vecs[13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ($urandom_range(0, 1) == 1);
      default: m_if.tready = 1'b0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard order, 1-cycle latency when never stalled, stability under stall.
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    int    c;
    got = '{data: m_if.tdata, keep: m_if.tkeep, last: m_if.tlast};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!m_if.tvalid || got !== prev_beat) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", m_if.tvalid, got, prev_beat);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        out_beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_beat: got unexpected beat %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL out_beat: got %h expected %h", got, e);
          end
          if (lat_q.size() != 0) begin
            c = lat_q.pop_front();
            if (ready_mode == 0) check("latency", 32'(cyc + 1), 32'(c + 1));
          end
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = got;
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 1;
  endfunction

  // Frame-level reference decision, taken from the current configuration.
  function automatic int decide(input logic [47:0] dst, input logic [15:0] et,
                                input logic [15:0] keep0, input bit last0);
    if (keep0[13:0] != 14'h3FFF) return KRunt;
    if (last0 && !keep0[13]) return KRunt;
    if (!cfg_enable) return KFwd;
    if ((dst == cfg_mac || (cfg_accept_bcast && dst == MacBcast)) && et == cfg_ethertype)
      return KFwd;
    return KDrop;
  endfunction

  task automatic send_beat(input beat_t b, input bit fwd);
    int waited = 0;
    s_if.tdata  = b.data;
    s_if.tkeep  = b.keep;
    s_if.tlast  = b.last;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      stalls++;
      waited++;
      if (waited > 500) begin
        total++;
        bad++;
        $display("FAIL in_accept: got tready=0 for 500 cycles expected acceptance");
        break;
      end
      @(posedge clk);
      #1;
    end
    if (fwd) lat_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et,
                            input logic [15:0] keep0, input int nbeats, input int kind,
                            input bit flip_cfg);
    beat_t       b;
    logic [47:0] saved_mac;
    saved_mac = cfg_mac;
    case (kind)
      KFwd:    exp_pass = sat_inc(exp_pass);
      KDrop:   exp_drop = sat_inc(exp_drop);
      default: exp_runt = sat_inc(exp_runt);
    endcase
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.last = (i == nbeats - 1);
      if (i == 0) begin
        b.data[47:0]   = dst;
        b.data[111:96] = {et[7:0], et[15:8]};
        b.keep         = keep0;
      end else begin
        b.keep = b.last ? (16'hFFFF >> $urandom_range(0, 15)) : 16'hFFFF;
      end
      if (kind == KFwd) exp_q.push_back(b);
      send_beat(b, kind == KFwd);
      if (i == 0 && flip_cfg) cfg_mac = ~cfg_mac;
    end
    cfg_mac     = saved_mac;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_pass"}, cnt_pass, exp_pass);
    check({tag, "_cnt_drop"}, cnt_drop, exp_drop);
    check({tag, "_cnt_runt"}, cnt_runt, exp_runt);
  endtask

  task automatic clear_counters();
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
    exp_runt = 0;
  endtask

  initial begin
    int ob;
    int st;
    int kind;
    logic [47:0] macs[3];
    logic [15:0] ets[2];
    logic [15:0] keeps[3];
    beat_t hb;

    macs  = '{MacSta, MacOther, MacBcast};
    ets   = '{16'h88B5, 16'h0800};
    keeps = '{16'hFFFF, 16'h3FFF, 16'h1FFF};

    vecs[0]  = '{MacSta,   16'h88B5, 16'hFFFF, 4, 1, 0, KFwd};
    vecs[1]  = '{MacOther, 16'h88B5, 16'hFFFF, 4, 1, 0, KDrop};
    vecs[2]  = '{MacSta,   16'h88B5, 16'hFFFF, 4, 1, 0, KFwd};
    vecs[3]  = '{MacBcast, 16'h88B5, 16'hFFFF, 2, 1, 0, KDrop};
    vecs[4]  = '{MacBcast, 16'h88B5, 16'hFFFF, 2, 1, 1, KFwd};
    vecs[5]  = '{MacSta,   16'h88B5, 16'h0FFF, 1, 1, 0, KRunt};
    vecs[6]  = '{MacSta,   16'h88B5, 16'h0FFF, 1, 0, 0, KRunt};
    vecs[7]  = '{MacSta,   16'h0800, 16'hFFFF, 3, 1, 0, KDrop};
    vecs[8]  = '{MacOther, 16'h1234, 16'hFFFF, 2, 0, 0, KFwd};
    vecs[9]  = '{MacSta,   16'h88B5, 16'h3FFF, 1, 1, 0, KFwd};
    vecs[10] = '{MacSta,   16'h88B5, 16'hFFFF, 1, 1, 0, KFwd};
    vecs[11] = '{MacSta,   16'h88B5, 16'h1FFF, 3, 0, 0, KRunt};
    vecs[12] = '{MacBcast, 16'h0800, 16'hFFFF, 2, 1, 1, KDrop};

    rst              = 1'b0;
    cfg_enable       = 1'b1;
    cfg_mac          = MacSta;
    cfg_ethertype    = 16'h88B5;
    cfg_accept_bcast = 1'b0;
    cnt_clear        = 1'b0;
    s_if.tvalid      = 1'b0;
    s_if.tdata       = '0;
    s_if.tkeep       = '0;
    s_if.tlast       = 1'b0;
    m_if.tready      = 1'b1;
    #2 rst = 1'b1;
    #3;
    check("rst_m_tvalid", 32'(m_if.tvalid), 0);
    check("rst_m_tdata_or", 32'(|m_if.tdata), 0);
    check("rst_m_tkeep", 32'(m_if.tkeep), 0);
    check("rst_m_tlast", 32'(m_if.tlast), 0);
    check_counters("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector table, always-ready sink.
    for (int i = 0; i < 13; i++) begin
      cfg_enable       = vecs[i].en;
      cfg_accept_bcast = vecs[i].bcast;
      ob = out_beats;
      st = stalls;
      send_frame(vecs[i].dst, vecs[i].et, vecs[i].keep0, vecs[i].nbeats, vecs[i].kind, 0);
      drain();
      check($sformatf("vec%0d_beats", i), 32'(out_beats - ob),
            (vecs[i].kind == KFwd) ? 32'(vecs[i].nbeats) : 32'd0);
      check($sformatf("vec%0d_stalls", i), 32'(stalls - st), 0);
      check_counters($sformatf("vec%0d", i));
    end

    // Dropped frame then matching frame back-to-back; cfg flipped mid-frame is ignored.
    cfg_enable       = 1'b1;
    cfg_accept_bcast = 1'b0;
    ob = out_beats;
    st = stalls;
    send_frame(MacOther, 16'h88B5, 16'hFFFF, 4, KDrop, 0);
    send_frame(MacSta, 16'h88B5, 16'hFFFF, 4, KFwd, 1);
    send_frame(MacSta, 16'h88B5, 16'hFFFF, 1, KFwd, 0);
    drain();
    check("b2b_beats", 32'(out_beats - ob), 5);
    check("b2b_stalls", 32'(stalls - st), 0);
    check_counters("b2b");

    // 100 matching 3-beat frames under random back-pressure.
    clear_counters();
    ready_mode = 1;
    ob = out_beats;
    for (int i = 0; i < 100; i++) begin
      send_frame(MacSta, 16'h88B5, 16'hFFFF, 3, decide(MacSta, 16'h88B5, 16'hFFFF, 0), 0);
    end
    drain();
    check("rand_beats", 32'(out_beats - ob), 300);
    check("rand_pass100", cnt_pass, 100);
    check_counters("rand");

    // Mixed random frames and configuration, judged by the model.
    for (int i = 0; i < 60; i++) begin
      logic [47:0] d;
      logic [15:0] e;
      logic [15:0] k;
      int          nb;
      cfg_enable       = ($urandom_range(0, 3) != 0);
      cfg_accept_bcast = ($urandom_range(0, 1) == 1);
      d  = macs[$urandom_range(0, 2)];
      e  = ets[$urandom_range(0, 1)];
      k  = keeps[$urandom_range(0, 2)];
      nb = int'($urandom_range(1, 4));
      kind = decide(d, e, k, nb == 1);
      send_frame(d, e, k, nb, kind, 0);
    end
    drain();
    check_counters("mixed");

    // Saturation, then clear coincident with a drop.
    ready_mode = 0;
    cfg_enable = 1'b1;
    @(posedge clk);
    #1;
    clear_counters();
    force dut.u_cnt_drop.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_cnt_drop.count_q;
    exp_drop = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) send_frame(MacOther, 16'h88B5, 16'hFFFF, 2, KDrop, 0);
    drain();
    check("sat_drop", cnt_drop, 32'hFFFF_FFFF);
    cnt_clear = 1'b1;
    send_frame(MacOther, 16'h88B5, 16'hFFFF, 1, KDrop, 0);
    cnt_clear = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
    exp_runt = 0;
    drain();
    check_counters("clr_prio");

    // Reset in the middle of a forwarded frame with the sink stalled.
    ready_mode = 2;
    @(posedge clk);
    #1;
    hb = '{data: {$urandom(), $urandom(), $urandom(), 16'h0000, 16'hB588, 48'h0, MacSta},
           keep: 16'hFFFF, last: 1'b0};
    exp_q.push_back(hb);
    send_beat(hb, 1);
    s_if.tvalid = 1'b0;
    check("midrst_held_valid", 32'(m_if.tvalid), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid_drop", 32'(m_if.tvalid), 0);
    exp_q.delete();
    lat_q.delete();
    exp_pass = 0;
    exp_drop = 0;
    exp_runt = 0;
    check_counters("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_frame(MacSta, 16'h88B5, 16'h0FFF, 1, KRunt, 0);
    drain();
    check_counters("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
